lcd_win_ctrl: RTL
=================

// Module: lcd_win_ctrl
// PURPOSE
//  Parametrised LCD window controller. Loads an IMG_W x IMG_H pixel image into an internal buffer, then streams a
//  WIN_W x WIN_H viewing window in raster order. Commands move the window with saturation or toggle X/Y mirroring.
//  Next-generation LCD front-end: generic image/window geometry, pixel width and mirror modes.
// PARAMETERS
//  DATA_W  8  pixel width in bits
//  IMG_W   8  image width in pixels (>=2)
//  IMG_H   8  image height in pixels (>=2)
//  WIN_W   3  window width in pixels (1..IMG_W)
//  WIN_H   3  window height in pixels (1..IMG_H)
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-high reset
//  datain        in   DATA_W  pixel input during Load
//  cmd           in   3       0 Reflash, 1 Load, 2 Right, 3 Left, 4 Up, 5 Down, 6 MirrorX, 7 MirrorY
//  cmd_valid     in   1       command strobe
//  dataout       out  DATA_W  window pixel, registered
//  output_valid  out  1       dataout valid this cycle
//  busy          out  1       command in progress; cmd_valid ignored while high
// BEHAVIOUR
//  Reset: dataout=0, output_valid=0, busy=0, FSM=IDLE, origin (ox,oy)=((IMG_W-WIN_W)/2,(IMG_H-WIN_H)/2),
//   mirx=miry=0. The image buffer is not reset; contents are undefined until the first Load.
//  Reset mid-operation aborts immediately. The next command starts from reset state.
//  Accept: cmd_valid && !busy at edge A; busy=1 from edge A. Commands arriving while busy are dropped, not queued.
//  FSM: IDLE -> LOAD (cmd 1) | MOVE (cmds 2-7) | OUT (cmd 0); LOAD -> OUT; MOVE -> OUT; OUT -> IDLE.
//  LOAD: datain sampled at edges A+1..A+N, N=IMG_W*IMG_H, in raster order (row 0 col 0 first).
//   At edge A+N+1: origin returns to centre, mirx=miry=0, FSM enters OUT.
//  MOVE (one cycle, edge A+1):
//   Right: ox=min(ox+1,IMG_W-WIN_W). Left: ox=max(ox-1,0).
//   Down:  oy=min(oy+1,IMG_H-WIN_H). Up:   oy=max(oy-1,0).
//   MirrorX: mirx toggles. MirrorY: miry toggles.
//   A saturated move leaves the origin unchanged but still produces a full output burst.
//  OUT: WIN_W*WIN_H beats on consecutive cycles, beat k=r*WIN_W+c.
//   dataout = img[oy+(miry?WIN_H-1-r:r)][ox+(mirx?WIN_W-1-c:c)], output_valid=1 for each beat.
//  Beat 0 timing: Reflash, after edge A+1. Move/mirror, after edge A+2. Load, after edge A+N+2.
//   Output_valid never gaps inside a burst.
//  The edge after the last beat clears output_valid and busy together, FSM=IDLE.
//   A new command can be accepted on the following edge.
//  dataout holds its last value while output_valid=0.
//  Address arithmetic: index widths are $clog2 of each dimension; computed addresses always stay in range.
// TESTING
//  (defaults 8x8 image, 3x3 window; Load pixel i = i for i=0..63)
//  1 Load -> busy for 64 sample cycles, then 9 valid beats: 18,19,20,26,27,28,34,35,36; busy/output_valid drop together.
//  2 Right x4 after Load -> ox 3,4,5,5; the 4th burst equals the 3rd (21,22,23,...), proving saturation.
//  3 Up x3 from centre -> oy 1,0,0; last burst 2,3,4,10,11,12,18,19,20; then Left x3 -> burst starts 0,1,2.
//  4 MirrorX at centre -> 20,19,18,28,27,26,36,35,34; MirrorY -> 36,35,34,28,27,26,20,19,18.
//   Reflash keeps mirroring; a new Load clears it.
//  5 cmd_valid held high with other cmds while busy -> ignored; beat count and data unchanged.
//   Back-to-back Reflash accepted exactly 1 cycle after busy falls.
//  6 reset asserted at Load pixel 30 -> outputs 0 immediately. A fresh full Load then gives burst 1 data.

Source files
------------

// File: rtl/lcd_win_ctrl.sv
// LCD window controller: buffers an IMG_W x IMG_H image and streams a movable,
// mirrorable WIN_W x WIN_H window of it in raster order.
module lcd_win_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned WIN_W  = 3,
  parameter int unsigned WIN_H  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              output_valid,
  output logic              busy
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned M  = WIN_W * WIN_H;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [XW-1:0] OX0   = XW'((IMG_W - WIN_W) / 2);
  localparam logic [YW-1:0] OY0   = YW'((IMG_H - WIN_H) / 2);
  localparam logic [XW-1:0] OXMAX = XW'(IMG_W - WIN_W);
  localparam logic [YW-1:0] OYMAX = YW'(IMG_H - WIN_H);
  localparam logic [XW-1:0] WW1   = XW'(WIN_W - 1);
  localparam logic [YW-1:0] WH1   = YW'(WIN_H - 1);
  localparam logic [CW-1:0] CNT_N = CW'(N);
  localparam logic [CW-1:0] CNT_M = CW'(M);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] MOVE = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [2:0] C_REFLASH = 3'd0;
  localparam logic [2:0] C_LOAD    = 3'd1;
  localparam logic [2:0] C_RIGHT   = 3'd2;
  localparam logic [2:0] C_LEFT    = 3'd3;
  localparam logic [2:0] C_UP      = 3'd4;
  localparam logic [2:0] C_DOWN    = 3'd5;
  localparam logic [2:0] C_MIRX    = 3'd6;
  localparam logic [2:0] C_MIRY    = 3'd7;

  logic [DATA_W-1:0] img [N];

  logic [1:0]    state;
  logic [2:0]    cmd_q;
  logic [CW-1:0] cnt;
  logic [XW-1:0] ox, bc, col_off, col;
  logic [YW-1:0] oy, br, row_off, row;
  logic          mirx, miry;
  logic [AW-1:0] rd_addr;

  // Window coordinates are always inside the image, so no clamping is needed here.
  always_comb begin
    col_off = mirx ? (WW1 - bc) : bc;
    row_off = miry ? (WH1 - br) : br;
    col     = ox + col_off;
    row     = oy + row_off;
    rd_addr = AW'(row * IMG_W + col);
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && cnt < CNT_N)
      img[AW'(cnt)] <= datain;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cmd_q        <= '0;
      cnt          <= '0;
      bc           <= '0;
      br           <= '0;
      ox           <= OX0;
      oy           <= OY0;
      mirx         <= 1'b0;
      miry         <= 1'b0;
      dataout      <= '0;
      output_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && !busy) begin
            busy  <= 1'b1;
            cmd_q <= cmd;
            cnt   <= '0;
            bc    <= '0;
            br    <= '0;
            if (cmd == C_LOAD)         state <= LOAD;
            else if (cmd == C_REFLASH) state <= OUT;
            else                       state <= MOVE;
          end
        end
        LOAD: begin
          // One extra cycle after the last sample re-centres before streaming.
          if (cnt == CNT_N) begin
            cnt   <= '0;
            ox    <= OX0;
            oy    <= OY0;
            mirx  <= 1'b0;
            miry  <= 1'b0;
            state <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MOVE: begin
          case (cmd_q)
            C_RIGHT: if (ox < OXMAX) ox <= ox + 1'b1;
            C_LEFT:  if (ox != '0)   ox <= ox - 1'b1;
            C_DOWN:  if (oy < OYMAX) oy <= oy + 1'b1;
            C_UP:    if (oy != '0)   oy <= oy - 1'b1;
            C_MIRX:  mirx <= ~mirx;
            C_MIRY:  miry <= ~miry;
            default: ;
          endcase
          state <= OUT;
        end
        OUT: begin
          if (cnt == CNT_M) begin
            output_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            dataout      <= img[rd_addr];
            output_valid <= 1'b1;
            cnt          <= cnt + 1'b1;
            if (bc == WW1) begin
              bc <= '0;
              br <= br + 1'b1;
            end else begin
              bc <= bc + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
